id_imm_stage: RTL and testbench



---
 rtl/id_imm_stage_pkg.sv | 37 +++
 rtl/id_imm_stage_imm_gen.sv | 37 +++
 rtl/id_imm_stage.sv | 95 +++++++++
 tb/tb_id_imm_stage.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/id_imm_stage_pkg.sv
// Shared constants for the ID immediate stage: RV32 opcodes, immediate-select codes and the NOP word.
`timescale 1ns/1ps
package id_imm_stage_pkg;

  localparam int          XLEN_DEF      = 32;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    IMM_SEL_I = 3'b000,
    IMM_SEL_S = 3'b001,
    IMM_SEL_B = 3'b010,
    IMM_SEL_U = 3'b011,
    IMM_SEL_J = 3'b100
  } imm_sel_e;

  // Every listed opcode already ends in 2'b11, so an opcode match also covers the compressed-encoding check.
  function automatic logic is_legal_opcode(input logic [6:0] opc);
    case (opc)
      OPC_OPIMM, OPC_LOAD, OPC_JALR, OPC_STORE, OPC_BRANCH, OPC_LUI,
      OPC_AUIPC, OPC_JAL, OPC_OP, OPC_FENCE, OPC_SYSTEM: is_legal_opcode = 1'b1;
      default:                                           is_legal_opcode = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/id_imm_stage_imm_gen.sv
// Combinational RV32 immediate generator: all five sign-extended immediates plus the mux select code.
`timescale 1ns/1ps
module imm_gen
  import id_imm_stage_pkg::*;
(
  input  logic [31:0] instr,
  output logic [31:0] imm_i,
  output logic [31:0] imm_s,
  output logic [31:0] imm_b,
  output logic [31:0] imm_u,
  output logic [31:0] imm_j,
  output logic [2:0]  imm_sel
);

  imm_sel_e sel;

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // Unknown opcodes fall back to the I-type select so the mux always sees a defined code.
  always_comb begin
    sel = IMM_SEL_I;
    case (instr[6:0])
      OPC_STORE:          sel = IMM_SEL_S;
      OPC_BRANCH:         sel = IMM_SEL_B;
      OPC_LUI, OPC_AUIPC: sel = IMM_SEL_U;
      OPC_JAL:            sel = IMM_SEL_J;
      default:            sel = IMM_SEL_I;
    endcase
  end

  assign imm_sel = sel;

endmodule

// File: rtl/id_imm_stage.sv
// ID-stage pipeline register with valid/ready handshake, stall and flush, feeding the immediate-select mux.
// Optional illegal-opcode flag is enabled by defining ID_IMM_ILLEGAL_DETECT_EN.
`timescale 1ns/1ps
module id_imm_stage
  import id_imm_stage_pkg::*;
#(
  parameter int          XLEN      = XLEN_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] imm_i,
  output logic [XLEN-1:0] imm_s,
  output logic [XLEN-1:0] imm_b,
  output logic [XLEN-1:0] imm_u,
  output logic [XLEN-1:0] imm_j,
  output logic [2:0]      imm_sel
`ifdef ID_IMM_ILLEGAL_DETECT_EN
  ,
  output logic            illegal_op
`endif
);

  logic [31:0] gen_i, gen_s, gen_b, gen_u, gen_j;
  logic [2:0]  gen_sel;
  logic        load;

  imm_gen u_imm_gen (
    .instr   (in_instr),
    .imm_i   (gen_i),
    .imm_s   (gen_s),
    .imm_b   (gen_b),
    .imm_u   (gen_u),
    .imm_j   (gen_j),
    .imm_sel (gen_sel)
  );

  assign in_ready = !out_valid || out_ready;
  assign load     = in_valid && in_ready && !flush;

  // Flush beats load beats drain; a stalled, unflushed stage falls through and holds everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_instr <= NOP_INSTR;
      out_pc    <= '0;
      imm_i     <= '0;
      imm_s     <= '0;
      imm_b     <= '0;
      imm_u     <= '0;
      imm_j     <= '0;
      imm_sel   <= IMM_SEL_I;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_instr <= NOP_INSTR;
    end else if (load) begin
      out_valid <= 1'b1;
      out_instr <= in_instr;
      out_pc    <= in_pc;
      imm_i     <= gen_i;
      imm_s     <= gen_s;
      imm_b     <= gen_b;
      imm_u     <= gen_u;
      imm_j     <= gen_j;
      imm_sel   <= gen_sel;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_instr <= NOP_INSTR;
    end
  end

`ifdef ID_IMM_ILLEGAL_DETECT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_op <= 1'b0;
    end else if (flush) begin
      illegal_op <= 1'b0;
    end else if (load) begin
      illegal_op <= (in_instr[1:0] != 2'b11) || !is_legal_opcode(in_instr[6:0]);
    end else if (out_ready) begin
      illegal_op <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_id_imm_stage.sv
// Self-checking bench for id_imm_stage: a cycle model built from the RV32 immediate rules plus literal spot checks.
`timescale 1ns/1ps
module tb_id_imm_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_instr = NOP;
  logic [31:0] in_pc = '0;
  logic        in_ready, out_valid;
  logic [31:0] out_instr, out_pc, imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [2:0]  imm_sel;
`ifdef ID_IMM_ILLEGAL_DETECT_EN
  logic        illegal_op;
`endif

  int total = 0;
  int bad = 0;

  id_imm_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_pc    (out_pc),
    .imm_i     (imm_i),
    .imm_s     (imm_s),
    .imm_b     (imm_b),
    .imm_u     (imm_u),
    .imm_j     (imm_j),
    .imm_sel   (imm_sel)
`ifdef ID_IMM_ILLEGAL_DETECT_EN
    ,
    .illegal_op(illegal_op)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference immediates as integer arithmetic on the instruction fields.
  function automatic logic [31:0] refImm(input logic [31:0] w, input int kind);
    int sgn;
    sgn = w[31] ? -1 : 0;
    case (kind)
      0: refImm = $signed(w) >>> 20;
      1: refImm = (sgn * 2048) + (((w >> 25) & 63) * 32) + ((w >> 7) & 31);
      2: refImm = (sgn * 4096) + (((w >> 7) & 1) * 2048) + (((w >> 25) & 63) * 32) + (((w >> 8) & 15) * 2);
      3: refImm = w & 32'hFFFF_F000;
      default: refImm = (sgn * 1048576) + (((w >> 12) & 255) * 4096) + (((w >> 20) & 1) * 2048) + (((w >> 21) & 1023) * 2);
    endcase
  endfunction

  function automatic logic [2:0] refSel(input logic [31:0] w);
    case (w[6:0])
      7'h23:        refSel = 3'd1;
      7'h63:        refSel = 3'd2;
      7'h37, 7'h17: refSel = 3'd3;
      7'h6F:        refSel = 3'd4;
      default:      refSel = 3'd0;
    endcase
  endfunction

  function automatic logic refIllegal(input logic [31:0] w);
    case (w[6:0])
      7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h0F, 7'h73:
        refIllegal = (w[1:0] != 2'b11);
      default: refIllegal = 1'b1;
    endcase
  endfunction

  logic        m_valid = 1'b0;
  logic [31:0] m_instr = NOP;
  logic [31:0] m_pc = '0;
  logic [31:0] m_imm [5];
  logic [2:0]  m_sel = '0;
  logic        m_ill = 1'b0;

  // Model of the stage register contents after each edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = 1'b0; m_instr = NOP; m_pc = '0; m_sel = '0; m_ill = 1'b0;
      for (int k = 0; k < 5; k++) m_imm[k] = '0;
    end else if (flush) begin
      m_valid = 1'b0; m_instr = NOP; m_ill = 1'b0;
    end else if (in_valid && (!m_valid || out_ready)) begin
      m_valid = 1'b1; m_instr = in_instr; m_pc = in_pc;
      m_sel = refSel(in_instr); m_ill = refIllegal(in_instr);
      for (int k = 0; k < 5; k++) m_imm[k] = refImm(in_instr, k);
    end else if (out_ready) begin
      m_valid = 1'b0; m_instr = NOP; m_ill = 1'b0;
    end
  end

  always @(negedge clk) begin
    checkOutput("in_ready", {31'b0, in_ready}, {31'b0, (!m_valid || out_ready)});
    checkOutput("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
    checkOutput("out_instr", out_instr, m_instr);
`ifdef ID_IMM_ILLEGAL_DETECT_EN
    checkOutput("illegal_op", {31'b0, illegal_op}, {31'b0, m_ill});
`endif
    if (m_valid) begin
      checkOutput("out_pc", out_pc, m_pc);
      checkOutput("imm_i", imm_i, m_imm[0]);
      checkOutput("imm_s", imm_s, m_imm[1]);
      checkOutput("imm_b", imm_b, m_imm[2]);
      checkOutput("imm_u", imm_u, m_imm[3]);
      checkOutput("imm_j", imm_j, m_imm[4]);
      checkOutput("imm_sel", {29'b0, imm_sel}, {29'b0, m_sel});
    end
  end

  task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                               input logic ordy, input logic fl);
    in_valid  = v;
    in_instr  = instr;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #12;
    checkOutput("rst out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("rst out_instr", out_instr, 32'h0000_0013);
    checkOutput("rst out_pc", out_pc, 32'd0);
    checkOutput("rst imm_i", imm_i, 32'd0);
    checkOutput("rst imm_j", imm_j, 32'd0);
    checkOutput("rst imm_sel", {29'b0, imm_sel}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    applyStimulus(1, 32'hFFF0_0093, 32'h100, 1, 0);
    checkOutput("addi valid", {31'b0, out_valid}, 32'd1);
    checkOutput("addi imm_i", imm_i, 32'hFFFF_FFFF);
    checkOutput("addi sel", {29'b0, imm_sel}, 32'd0);
    checkOutput("addi pc", out_pc, 32'h100);

    applyStimulus(1, 32'h0011_2623, 32'h104, 1, 0);
    checkOutput("sw imm_s", imm_s, 32'h0000_000C);
    checkOutput("sw sel", {29'b0, imm_sel}, 32'd1);
    applyStimulus(1, 32'hFE00_0EE3, 32'h108, 1, 0);
    checkOutput("beq imm_b", imm_b, 32'hFFFF_FFFC);
    checkOutput("beq sel", {29'b0, imm_sel}, 32'd2);
    applyStimulus(1, 32'h1234_52B7, 32'h10C, 1, 0);
    checkOutput("lui imm_u", imm_u, 32'h1234_5000);
    checkOutput("lui sel", {29'b0, imm_sel}, 32'd3);
    applyStimulus(1, 32'h0010_00EF, 32'h110, 1, 0);
    checkOutput("jal imm_j", imm_j, 32'h0000_0800);
    checkOutput("jal sel", {29'b0, imm_sel}, 32'd4);

    // Stall for three cycles while fetch keeps offering the next instruction.
    applyStimulus(1, 32'h0050_0113, 32'h114, 1, 0);
    for (int n = 0; n < 3; n++) begin
      applyStimulus(1, 32'h00A0_0193, 32'h118, 0, 0);
      checkOutput("stall in_ready", {31'b0, in_ready}, 32'd0);
      checkOutput("stall instr", out_instr, 32'h0050_0113);
      checkOutput("stall pc", out_pc, 32'h114);
    end
    applyStimulus(1, 32'h00A0_0193, 32'h118, 1, 0);
    checkOutput("release instr", out_instr, 32'h00A0_0193);
    checkOutput("release pc", out_pc, 32'h118);
    applyStimulus(0, 32'h00A0_0193, 32'h118, 1, 0);
    checkOutput("drain valid", {31'b0, out_valid}, 32'd0);
    checkOutput("drain instr", out_instr, 32'h0000_0013);

    applyStimulus(1, 32'h0010_0093, 32'h11C, 1, 0);
    applyStimulus(1, 32'h0020_0093, 32'h120, 1, 1);
    checkOutput("flush valid", {31'b0, out_valid}, 32'd0);
    checkOutput("flush instr", out_instr, 32'h0000_0013);
    applyStimulus(0, 32'h0000_0013, 32'h0, 1, 0);
    checkOutput("flush dropped", {31'b0, out_valid}, 32'd0);

    applyStimulus(1, 32'h0000_007F, 32'h124, 1, 0);
    checkOutput("unknown sel", {29'b0, imm_sel}, 32'd0);
`ifdef ID_IMM_ILLEGAL_DETECT_EN
    checkOutput("illegal 7F", {31'b0, illegal_op}, 32'd1);
`endif
    applyStimulus(1, 32'h0020_8033, 32'h128, 1, 0);
`ifdef ID_IMM_ILLEGAL_DETECT_EN
    checkOutput("legal add", {31'b0, illegal_op}, 32'd0);
`endif
    applyStimulus(1, 32'h0000_007C, 32'h12C, 1, 0);
    applyStimulus(1, 32'h0000_0017, 32'h130, 0, 0);
    applyStimulus(1, 32'h8000_0063, 32'h134, 1, 0);

    // Mixed handshake traffic; the per-cycle model does the checking.
    for (int n = 0; n < 40; n++) begin
      applyStimulus(1'($urandom_range(0, 1)), $urandom, 32'h200 + 32'(n * 4),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0));
    end

    applyStimulus(1, 32'h8765_4337, 32'h300, 1, 0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async valid", {31'b0, out_valid}, 32'd0);
    checkOutput("async instr", out_instr, 32'h0000_0013);
    checkOutput("async pc", out_pc, 32'd0);
    checkOutput("async imm_u", imm_u, 32'd0);
    checkOutput("async sel", {29'b0, imm_sel}, 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(1, 32'h0040_0093, 32'h304, 1, 0);
    applyStimulus(0, 32'h0000_0013, 32'h0, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
